// File: rtl/io_mmio.sv
// io_mmio: memory-mapped I/O registers at 0x7000-0x7003.
//   0x7000 controller 1 buttons, 0x7001 controller 2 buttons,
//   0x7002 in_vblank level, 0x7003 vblank IRQ latch (write clears).
// Scans both serial controllers once per frame, starting on vblank_start.
// Optional feature macro: IO_MMIO_CONTROLLER_2_EN (controller 2 scan and
// readback; without it 0x7001 reads 0x00 and controller_data_2 is ignored).
module io_mmio #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_address_lsb,
    input  logic       cpu_wen,
    input  logic [7:0] cpu_data_in,
    input  logic       SELECT_controller,
    input  logic       SELECT_in_vblank,
    input  logic       SELECT_clr_vblank_irq,
    input  logic       vblank_start,
    input  logic       in_vblank,
    input  logic       controller_data_1,
    input  logic       controller_data_2,
    output logic       controller_latch,
    output logic       controller_pulse,
    output logic [7:0] cpu_data_out,
    output logic       vblank_irq_n
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sr1_q, sr1_d;
    logic [7:0]      sh1_q, sh1_d;
    logic            latch_q, latch_d;
    logic            pulse_q, pulse_d;
    logic            irq_q, irq_d;
    logic            tick;

`ifdef IO_MMIO_CONTROLLER_2_EN
    logic [7:0]      sr2_q, sr2_d;
    logic [7:0]      sh2_q, sh2_d;
`endif

    // Write data carries no meaning here; only the write event matters.
    logic unused_inputs;
`ifdef IO_MMIO_CONTROLLER_2_EN
    assign unused_inputs = ^cpu_data_in;
`else
    assign unused_inputs = ^{cpu_data_in, controller_data_2};
`endif

    // Next-state logic for the scan FSM, shift/shadow registers and IRQ latch.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr1_d   = sr1_q;
        sh1_d   = sh1_q;
`ifdef IO_MMIO_CONTROLLER_2_EN
        sr2_d   = sr2_q;
        sh2_d   = sh2_q;
`endif
        tick = (state_q != S_IDLE) && (cnt_q == TICK_MAX);

        // Phase timer runs only while scanning and restarts on every tick.
        if (state_q == S_IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // vblank_start elsewhere is ignored: a running scan is never restarted.
                if (vblank_start) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (tick) begin
                    state_d = S_LOW;
                    bit_d   = 3'd0;
                end
            end
            S_LOW: begin
                // Controllers drive active-low data; store pressed as 1, MSB first.
                if (tick) begin
                    sr1_d   = {sr1_q[6:0], ~controller_data_1};
`ifdef IO_MMIO_CONTROLLER_2_EN
                    sr2_d   = {sr2_q[6:0], ~controller_data_2};
`endif
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        // Shadow copy in one edge so CPU reads never see a partial frame.
                        sh1_d   = sr1_q;
`ifdef IO_MMIO_CONTROLLER_2_EN
                        sh2_d   = sr2_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_LOW;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they change with the state flop.
        latch_d = (state_d == S_LATCH);
        pulse_d = (state_d != S_LOW);

        // Set wins over a coincident clear.
        if (vblank_start) begin
            irq_d = 1'b1;
        end else if (SELECT_clr_vblank_irq && cpu_wen) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State registers; asynchronous reset discards any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sr1_q   <= 8'h00;
            sh1_q   <= 8'h00;
`ifdef IO_MMIO_CONTROLLER_2_EN
            sr2_q   <= 8'h00;
            sh2_q   <= 8'h00;
`endif
            latch_q <= 1'b0;
            pulse_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr1_q   <= sr1_d;
            sh1_q   <= sh1_d;
`ifdef IO_MMIO_CONTROLLER_2_EN
            sr2_q   <= sr2_d;
            sh2_q   <= sh2_d;
`endif
            latch_q <= latch_d;
            pulse_q <= pulse_d;
            irq_q   <= irq_d;
        end
    end

    assign controller_latch = latch_q;
    assign controller_pulse = pulse_q;
    assign vblank_irq_n     = ~irq_q;

    // Zero-latency read mux from registered state and the in_vblank level.
    always_comb begin
        cpu_data_out = 8'h00;
        if (SELECT_controller) begin
            if (!cpu_address_lsb) begin
                cpu_data_out = sh1_q;
            end else begin
`ifdef IO_MMIO_CONTROLLER_2_EN
                cpu_data_out = sh2_q;
`else
                cpu_data_out = 8'h00;
`endif
            end
        end else if (SELECT_in_vblank) begin
            cpu_data_out = {7'b0, in_vblank};
        end else if (SELECT_clr_vblank_irq) begin
            cpu_data_out = {7'b0, irq_q};
        end
    end

endmodule

// File: tb/tb_io_mmio.sv
// Scoreboard bench for io_mmio (CLK_DIV=4): stimulus pushes expectations,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_io_mmio;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_address_lsb;
    logic       cpu_wen;
    logic [7:0] cpu_data_in;
    logic       SELECT_controller;
    logic       SELECT_in_vblank;
    logic       SELECT_clr_vblank_irq;
    logic       vblank_start;
    logic       in_vblank;
    logic       controller_data_1;
    logic       controller_data_2;
    logic       controller_latch;
    logic       controller_pulse;
    logic [7:0] cpu_data_out;
    logic       vblank_irq_n;

    typedef enum {K_DATA, K_IRQN, K_LATCH, K_PULSE} kind_e;
    typedef struct {
        string      name;
        kind_e      kind;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef IO_MMIO_CONTROLLER_2_EN
    localparam logic [7:0] C2_SCAN1 = 8'h01;
    localparam logic [7:0] C2_SCAN2 = 8'h80;
`else
    localparam logic [7:0] C2_SCAN1 = 8'h00;
    localparam logic [7:0] C2_SCAN2 = 8'h00;
`endif

    io_mmio #(.CLK_DIV(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cpu_address_lsb       (cpu_address_lsb),
        .cpu_wen               (cpu_wen),
        .cpu_data_in           (cpu_data_in),
        .SELECT_controller     (SELECT_controller),
        .SELECT_in_vblank      (SELECT_in_vblank),
        .SELECT_clr_vblank_irq (SELECT_clr_vblank_irq),
        .vblank_start          (vblank_start),
        .in_vblank             (in_vblank),
        .controller_data_1     (controller_data_1),
        .controller_data_2     (controller_data_2),
        .controller_latch      (controller_latch),
        .controller_pulse      (controller_pulse),
        .cpu_data_out          (cpu_data_out),
        .vblank_irq_n          (vblank_irq_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare everything queued so far against the DUT outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_DATA:  act = cpu_data_out;
                K_IRQN:  act = {7'b0, vblank_irq_n};
                K_LATCH: act = {7'b0, controller_latch};
                default: act = {7'b0, controller_pulse};
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic push(input string n, input kind_e k, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address 0..3 -> 0x7000..0x7003, anything else -> no select.
    task automatic set_sel(input int a);
        SELECT_controller     = (a == 0 || a == 1);
        SELECT_in_vblank      = (a == 2);
        SELECT_clr_vblank_irq = (a == 3);
        cpu_address_lsb       = (a == 1 || a == 3);
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string nm);
        set_sel(a);
        push(nm, K_DATA, exp);
        tick();
        set_sel(4);
    endtask

    task automatic wr(input int a);
        set_sel(a);
        cpu_wen = 1'b1;
        tick();
        cpu_wen = 1'b0;
        set_sel(4);
    endtask

    // Full scan: pulse vblank_start (edge E), then walk 68 cycles checking the
    // latch/pulse waveform and presenting serial data bits MSB first.
    task automatic scan(input logic [7:0] p1, input logic [7:0] p2, input int retrig,
                        input int rd_at, input logic [7:0] rd_exp);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        for (int c = 0; c < 68; c++) begin
            int idx;
            logic lo;
            idx = (c < 4) ? 0 : (c - 4) / 8;
            lo  = (c >= 4) && (((c - 4) / 4) % 2 == 0);
            controller_data_1 = p1[7 - idx];
            controller_data_2 = p2[7 - idx];
            vblank_start = (c == retrig);
            push("latch_wave", K_LATCH, {7'b0, c < 4});
            push("pulse_wave", K_PULSE, {7'b0, !lo});
            if (c == rd_at) begin
                set_sel(0);
                push("atomic_read", K_DATA, rd_exp);
            end else begin
                set_sel(4);
            end
            tick();
        end
        vblank_start      = 1'b0;
        controller_data_1 = 1'b1;
        controller_data_2 = 1'b1;
        set_sel(4);
        push("idle_latch", K_LATCH, 8'h00);
        push("idle_pulse", K_PULSE, 8'h01);
    endtask

    initial begin
        rst = 1'b1;
        cpu_wen = 1'b0;
        cpu_data_in = 8'h5A;
        vblank_start = 1'b0;
        in_vblank = 1'b0;
        controller_data_1 = 1'b1;
        controller_data_2 = 1'b1;
        set_sel(4);
        #1;

        // Reset state
        push("rst_latch", K_LATCH, 8'h00);
        push("rst_pulse", K_PULSE, 8'h01);
        push("rst_irqn", K_IRQN, 8'h01);
        push("rst_nosel", K_DATA, 8'h00);
        tick();
        rd(0, 8'h00, "rst_rd_7000");
        rst = 1'b0;
        tick();

        // Scan 1: ctl1 0b01011010 -> 0xA5, ctl2 0b11111110 -> 0x01
        scan(8'b01011010, 8'b11111110, -1, -1, 8'h00);
        rd(0, 8'hA5, "scan1_7000");
        rd(1, C2_SCAN1, "scan1_7001");

        // Scan 2 with retrigger at E+30 and a mid-scan read at E+40
        scan(8'b00111100, 8'b01111111, 29, 40, 8'hA5);
        rd(0, 8'hC3, "scan2_7000");
        rd(1, C2_SCAN2, "scan2_7001");

        // IRQ latch still set from vblank_start
        push("irq_set", K_IRQN, 8'h00);
        rd(3, 8'h01, "irq_rd_7003");
        // Writes to 0x7000 and 0x7002 change nothing
        wr(0);
        wr(2);
        push("irq_after_wr", K_IRQN, 8'h00);
        rd(0, 8'hC3, "wr_noeffect");
        // Clear write
        wr(3);
        push("irq_clear", K_IRQN, 8'h01);
        rd(3, 8'h00, "irq_rd_clr");

        // Misc reads
        in_vblank = 1'b1;
        rd(2, 8'h01, "in_vblank_1");
        in_vblank = 1'b0;
        rd(2, 8'h00, "in_vblank_0");
        rd(4, 8'h00, "no_select");

        // Clear coincident with vblank_start: set wins (also starts a scan)
        set_sel(3);
        cpu_wen = 1'b1;
        vblank_start = 1'b1;
        tick();
        cpu_wen = 1'b0;
        vblank_start = 1'b0;
        set_sel(4);
        push("irq_coincident", K_IRQN, 8'h00);
        rd(3, 8'h01, "irq_rd_coinc");
        repeat (70) tick();
        rd(0, 8'h00, "released_scan");
        wr(3);
        push("irq_clear2", K_IRQN, 8'h01);
        tick();

        // Reset mid-scan at E+20, all buttons pressed
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        controller_data_1 = 1'b0;
        controller_data_2 = 1'b0;
        repeat (19) tick();
        push("pre_rst_irqn", K_IRQN, 8'h00);
        push("pre_rst_pulse", K_PULSE, 8'h01);
        tick();
        rst = 1'b1;
        set_sel(0);
        push("midrst_latch", K_LATCH, 8'h00);
        push("midrst_pulse", K_PULSE, 8'h01);
        push("midrst_irqn", K_IRQN, 8'h01);
        push("midrst_7000", K_DATA, 8'h00);
        @(negedge clk);
        #1;
        tick();
        rst = 1'b0;
        set_sel(4);
        repeat (60) tick();
        push("post_rst_latch", K_LATCH, 8'h00);
        push("post_rst_pulse", K_PULSE, 8'h01);
        rd(0, 8'h00, "post_rst_7000");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_mmio.md
# io_mmio

Memory-mapped I/O register block sitting directly downstream of the address decoder. It consumes the decoder's `SELECT_controller`, `SELECT_in_vblank` and `SELECT_clr_vblank_irq` strobes plus the low address bit. It serves CPU reads and writes at 0x7000–0x7003, scans the serial game controllers once per frame and owns the vblank IRQ latch driving the CPU's active-low IRQ line.

## Interface
Parameters:
- `CLK_DIV`, default 4: clock cycles per controller scan phase; legal range ≥ 1. Tick counter width is `$clog2(CLK_DIV)`, minimum 1 bit.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `cpu_address_lsb`  input  1  bit 0 of the decoder's `output_address`; selects the register within a pair.
- `cpu_wen`  input  1  CPU write strobe, sampled on `clk`.
- `cpu_data_in`  input  8  CPU write data; value ignored, only the write event matters.
- `SELECT_controller`  input  1  decoder strobe for 0x7000/0x7001.
- `SELECT_in_vblank`  input  1  decoder strobe for 0x7002.
- `SELECT_clr_vblank_irq`  input  1  decoder strobe for 0x7003.
- `vblank_start`  input  1  one-cycle pulse from video timing at the start of vblank.
- `in_vblank`  input  1  level from video timing, high during vblank.
- `controller_data_1`  input  1  serial data from controller 1; active-low, 0 = pressed.
- `controller_data_2`  input  1  serial data from controller 2; active-low.
- `controller_latch`  output  1  parallel-load strobe to both controllers.
- `controller_pulse`  output  1  shift clock to both controllers; idles high.
- `cpu_data_out`  output  8  read data.
- `vblank_irq_n`  output  1  active-low IRQ to the CPU.

## Operation
- Scan FSM states: IDLE, LATCH, LOW, HIGH. There is a 3-bit bit index, a tick counter, per-controller 8-bit shift registers and per-controller 8-bit shadow registers.
- Tick counter: cleared when entering LATCH and on every tick. Tick = counter == CLK_DIV−1 while the state is not IDLE.
- IDLE: if `vblank_start`=1, go to LATCH. Otherwise stay.
- LATCH: on tick, go to LOW and set bit index to 0.
- LOW: on tick, shift the inverted serial data into each shift register, MSB first (`sr <= {sr[6:0], ~data}`), then go to HIGH.
- HIGH: on tick, if bit index is 7, copy the shift registers into the shadow registers and go to IDLE. Otherwise increment the bit index and go to LOW.
- A `vblank_start` pulse outside IDLE is ignored. The scan in progress is not restarted.
- Output decode from the state register: `controller_latch` = (state==LATCH). `controller_pulse` = 0 only in LOW.
- The first sampled bit ends up in shadow bit 7. Pressed buttons read as 1.
- IRQ latch: set by `vblank_start` and cleared by `SELECT_clr_vblank_irq & cpu_wen`. If both happen in the same cycle, set wins. `vblank_irq_n` = ~latch.
- Read mux, combinational from registered state and `in_vblank`:
  - `SELECT_controller` with lsb 0: shadow 1.
  - `SELECT_controller` with lsb 1: shadow 2.
  - `SELECT_in_vblank`: {7'b0, in_vblank}.
  - `SELECT_clr_vblank_irq`: {7'b0, irq latch}.
  - No select active: 0x00.
- Writes to 0x7000–0x7002 have no effect.

## Timing
- Reset values:
  - state IDLE; tick counter, bit index, shift registers and shadow registers all 0; IRQ latch 0.
  - `controller_latch`=0, `controller_pulse`=1, `vblank_irq_n`=1.
  - `cpu_data_out`=0x00 with no select active.
- On edge E where `vblank_start`=1, state becomes LATCH. `controller_latch` is high for exactly CLK_DIV cycles.
- Then there are 8 LOW/HIGH pairs, each phase CLK_DIV cycles long. Data is sampled at the edge ending each LOW.
- Shadow registers update at edge E + 17·CLK_DIV. The state is IDLE from that edge.
- Shadow updates are atomic. CPU reads during a scan return the previous frame's value.
- `vblank_irq_n` falls on the edge where `vblank_start` is sampled. It rises on the edge where the clear write is sampled.
- Read data has zero cycles of latency from the select and lsb inputs.
- Reset asserted mid-scan: immediate return to reset values. The partial scan is discarded and no shadow update occurs.

## Configuration
- `IO_MMIO_CONTROLLER_2_EN` defined: controller 2 is scanned and 0x7001 returns shadow 2.
- Undefined:
  - The controller 2 shift and shadow registers are not built.
  - `controller_data_2` is ignored and 0x7001 reads 0x00.
  - Controller 1 behaviour and scan timing are unchanged.

## Test plan
- Reset check: assert `rst` mid-scan at cycle 20 (CLK_DIV=4). Required: outputs return to reset values immediately, and reading 0x7000 returns 0x00.
- Full scan:
  - Stimulus: CLK_DIV=4, `vblank_start` pulse. Controller 1 presents active-low 0b01011010 and controller 2 presents 0b11111110, MSB first.
  - Required: latch high for 4 cycles, 8 low pulses of 4 cycles each.
  - Required at E+68: 0x7000 reads 0xA5 and 0x7001 reads 0x01.
- Atomicity: read 0x7000 at E+40 during a second scan. Required: previous value 0xA5 is returned.
- IRQ:
  - `vblank_start` pulse → `vblank_irq_n`=0 and 0x7003 reads 0x01.
  - Write to 0x7003 → `vblank_irq_n`=1 next edge.
  - Write coincident with `vblank_start` → stays 0.
- Ignored retrigger: second `vblank_start` at E+30. Required: the scan still completes at E+68 with no restart.
- Misc reads: with `in_vblank`=1, 0x7002 reads 0x01. With no select active, the read returns 0x00. Without `IO_MMIO_CONTROLLER_2_EN`, 0x7001 reads 0x00.
